// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings and default widths for the IF/MEM single-port SRAM arbiter.
package sram_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF       = 32;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic {
    RESP_SRC_IF  = 1'b0,
    RESP_SRC_MEM = 1'b1
  } resp_src_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-side signal bundle; slave = arbiter view, master = environment view.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_req;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              sram_en;
  logic [BE_W-1:0]   sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
    output if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
           sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
    input  if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
           sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter_resp_tracker.sv
// Remembers who owns the read issued last cycle and routes the SRAM read data back to it.
module sram_resp_tracker
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rd_gnt,
  input  resp_src_e         i_rd_src,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_mem_rvalid,
  output logic [DATA_W-1:0] o_mem_rdata
);

  logic      r_resp_vld;
  resp_src_e r_resp_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_vld <= 1'b0;
      r_resp_src <= RESP_SRC_IF;
    end else begin
      r_resp_vld <= i_rd_gnt;
      r_resp_src <= i_rd_gnt ? i_rd_src : RESP_SRC_IF;
    end
  end

  // Data is passed through unqualified; rvalid alone marks it meaningful.
  assign o_if_rvalid  = r_resp_vld && (r_resp_src == RESP_SRC_IF);
  assign o_mem_rvalid = r_resp_vld && (r_resp_src == RESP_SRC_MEM);
  assign o_if_rdata   = i_sram_rdata;
  assign o_mem_rdata  = i_sram_rdata;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between IF fetch and MEM data requesters, MEM priority.
// Optional IF anti-starvation guard enabled by defining STARVE_GUARD_EN.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  sram_port_arbiter_if.slave  bus
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic      w_if_force;
  logic      w_if_gnt;
  logic      w_mem_gnt;
  logic      w_rd_gnt;
  resp_src_e w_rd_src;

`ifdef STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;

  assign w_if_force = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts consecutive IF losses; any IF win or idle IF restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (bus.if_req && !w_if_gnt) begin
      if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end
`else
  assign w_if_force = 1'b0;
`endif

  assign w_if_gnt  = !reset && bus.if_req && (!bus.mem_req || w_if_force);
  assign w_mem_gnt = !reset && bus.mem_req && !(bus.if_req && w_if_force);

  assign bus.if_gnt     = w_if_gnt;
  assign bus.mem_gnt    = w_mem_gnt;
  assign bus.sram_en    = w_if_gnt || w_mem_gnt;
  assign bus.sram_we    = w_mem_gnt ? bus.mem_we : BE_W'(0);
  assign bus.sram_addr  = w_mem_gnt ? bus.mem_addr : bus.if_addr;
  assign bus.sram_wdata = bus.mem_wdata;

  assign w_rd_gnt = w_if_gnt || (w_mem_gnt && (bus.mem_we == BE_W'(0)));
  assign w_rd_src = w_mem_gnt ? RESP_SRC_MEM : RESP_SRC_IF;

  sram_resp_tracker #(
    .DATA_W (DATA_W)
  ) u_resp_tracker (
    .clk          (clk),
    .reset        (reset),
    .i_rd_gnt     (w_rd_gnt),
    .i_rd_src     (w_rd_src),
    .i_sram_rdata (bus.sram_rdata),
    .o_if_rvalid  (bus.if_rvalid),
    .o_if_rdata   (bus.if_rdata),
    .o_mem_rvalid (bus.mem_rvalid),
    .o_mem_rdata  (bus.mem_rdata)
  );

endmodule
